serial_paralelo_param: RTL

//  Parametrised serial-to-parallel deserializer for the PHY receive path, clocked by the bit clock only.

---
 rtl/serial_paralelo_param.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_paralelo_param.sv
// Serial-to-parallel deserializer: slides over the bit stream for COMMA, aligns, locks, emits words.
// Optional SP_RELOCK_EN: drop lock after UNLOCK_COUNT consecutive all-zero words.
module serial_paralelo_param #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] COMMA        = WIDTH'(8'hBC),
  parameter int               LOCK_COUNT   = 4,
  parameter int               UNLOCK_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int ZW = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [CW-1:0]    comma_cnt, comma_n;
  logic [ZW-1:0]    zero_cnt, zero_n;
  logic [WIDTH-1:0] data_n;
  logic             valid_n, active_n;
  logic             boundary;

  assign nxt      = {shreg[WIDTH-2:0], data_in};
  assign boundary = (bit_cnt == BW'(WIDTH - 1));

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      shreg     <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      zero_cnt  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= nxt;
      bit_cnt   <= bit_cnt_n;
      comma_cnt <= comma_n;
      zero_cnt  <= zero_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      active    <= active_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    comma_n   = comma_cnt;
    zero_n    = zero_cnt;
    data_n    = data_out;
    valid_n   = valid_out;
    active_n  = active;
    unique case (state)
      SEARCH: begin
        // Sliding compare: any bit offset may start a word boundary.
        bit_cnt_n = '0;
        valid_n   = 1'b0;
        zero_n    = '0;
        if (nxt == COMMA) begin
          comma_n = CW'(1);
          if (LOCK_COUNT == 1) begin
            state_n  = LOCKED;
            active_n = 1'b1;
          end else begin
            state_n = ALIGN;
          end
        end
      end
      ALIGN: begin
        bit_cnt_n = boundary ? '0 : BW'(bit_cnt + 1'b1);
        valid_n   = 1'b0;
        zero_n    = '0;
        if (boundary) begin
          if (nxt == COMMA) begin
            if (comma_cnt >= CW'(LOCK_COUNT - 1)) begin
              comma_n  = CW'(LOCK_COUNT);
              state_n  = LOCKED;
              active_n = 1'b1;
            end else begin
              comma_n = CW'(comma_cnt + 1'b1);
            end
          end else begin
            state_n = SEARCH;
            comma_n = '0;
          end
        end
      end
      LOCKED: begin
        bit_cnt_n = boundary ? '0 : BW'(bit_cnt + 1'b1);
        if (boundary) begin
          data_n  = nxt;
          valid_n = (nxt != COMMA);
          if (nxt == '0)
            zero_n = (zero_cnt == ZW'(UNLOCK_COUNT)) ? zero_cnt : ZW'(zero_cnt + 1'b1);
          else
            zero_n = '0;
`ifdef SP_RELOCK_EN
          // Link presumed dead: the last payload word stays visible, nothing is flagged valid.
          if (nxt == '0 && zero_cnt >= ZW'(UNLOCK_COUNT - 1)) begin
            state_n   = SEARCH;
            active_n  = 1'b0;
            valid_n   = 1'b0;
            data_n    = data_out;
            comma_n   = '0;
            zero_n    = '0;
            bit_cnt_n = '0;
          end
`endif
        end
      end
      default: state_n = SEARCH;
    endcase
  end

endmodule
